adc_trigger_capture: RTL and testbench
======================================

// Module: adc_trigger_capture
// PURPOSE
// - Downstream consumer of the 20-tap ADC sample delay line. Watches live ADC samples for a rising
//   threshold crossing, then records DEPTH samples from the delay line's last tap (DelayT) into a buffer.
// - Because the captured stream lags the live stream by 20 clk, every capture starts with 20 pre-trigger samples.
// - Drains the buffer as a byte stream over a valid/ready handshake to the UART transmitter.
// PARAMETERS
// - SAMPLE_W  14    ADC sample width (bits); must be 9..16
// - DEPTH     64    samples per capture; power of two, 2..4096
// - HEADER    8'hA5 frame-start byte sent before sample data
// PORTS
// - clk        in   1         sample clock, shared with delay line and ADC
// - rst_n      in   1         asynchronous active-low reset
// - trig_in    in   SAMPLE_W  live (undelayed) ADC sample, unsigned
// - sample_in  in   SAMPLE_W  delayed sample from the delay line's last tap, unsigned
// - threshold  in   SAMPLE_W  trigger level, unsigned; latched on arm
// - arm        in   1         single-cycle request to start one capture
// - tx_data    out  8         byte to UART transmitter
// - tx_valid   out  1         tx_data valid
// - tx_ready   in   1         UART transmitter accepts byte this cycle
// - busy       out  1         high in every state except IDLE
// - done       out  1         one-cycle pulse after final byte accepted
// BEHAVIOUR
// - One clock (clk); reset asynchronous, active-low (rst_n). In reset: state=IDLE, tx_data=0, tx_valid=0,
//   busy=0, done=0, thr_q=0, prev_q=0, counters=0. Buffer contents are not reset.
// - prev_q <= trig_in every cycle, in all states. Crossing = (prev_q < thr_q) && (trig_in >= thr_q).
// - IDLE:    arm=1 -> thr_q<=threshold, go ARMED. arm in any other state is ignored.
// - ARMED:   crossing -> go CAPTURE. The sample_in of the crossing cycle is written to addr 0 in that same cycle.
//            thr_q=0 can never trigger; block stays ARMED until reset.
// - CAPTURE: writes sample_in at addr 1..DEPTH-1 on consecutive cycles, with no gaps and no handshake.
//            After addr DEPTH-1 is written -> SEND. Further crossings are ignored.
// - SEND:    byte order = HEADER, then for i=0..DEPTH-1: hi byte {zero-pad, s[i][SAMPLE_W-1:8]}, lo byte s[i][7:0].
//            Total = 1+2*DEPTH bytes. Up to DEPTH-1 the read address never wraps.
// - Handshake: a byte is accepted when tx_valid && tx_ready. While tx_valid=1 && tx_ready=0,
//   tx_data must hold stable. tx_valid is never withdrawn before acceptance.
//   The next byte may be presented in the cycle after acceptance. Throughput is 1 byte/clk when tx_ready is held high.
// - Buffer read latency is 1 cycle. Prefetch so that gaps never come from the RAM; stalls come only from tx_ready.
// - Last byte accepted -> tx_valid=0, done=1 for one cycle, go IDLE.
//   An arm in the cycle done=1 is ignored (state still SEND). An arm in the next cycle is honoured.
// - Latency: first HEADER presented ≤2 clk after the last CAPTURE write.
// - rst_n asserted mid-CAPTURE or mid-SEND: immediate abort to IDLE, tx_valid=0. The partial frame is lost.
// - busy = (state != IDLE); combinational from the state register.
// STRUCTURE
// - Package adc_cap_pkg: state enum {IDLE, ARMED, CAPTURE, SEND}, SAMPLE_W default, HEADER constant,
//   localparam function for addr width = $clog2(DEPTH).
// - Sub-module capture_ram: simple dual-port, 1 write / 1 read port, registered read, DEPTH x SAMPLE_W.
//   Inferable as M10K; no reset.
// - Top level: FSM, threshold/prev registers, write counter, read counter plus hi/lo byte phase,
//   1-entry output register with holding logic.
// TESTING
// - Basic capture: SAMPLE_W=14, DEPTH=8; arm with threshold=0x1000; ramp trig_in 0x0FF0 -> 0x1010 step 0x10,
//   sample_in = trig_in delayed 20 clk; tx_ready=1.
//   Expect 17 bytes: A5, then 8 hi/lo pairs equal to the sample_in values from the crossing cycle onward; done pulses once.
// - No trigger: levels stay at 0x0FFF, or start already ≥ threshold and never fall below it.
//   Expect state stays ARMED, no tx_valid.
// - Backpressure: tx_ready toggles 1,0,0,1,... and random.
//   Expect tx_data stable while stalled, no byte dropped or duplicated, byte count = 1+2*DEPTH.
// - Reset mid-SEND: drop rst_n after 5 bytes accepted.
//   Expect tx_valid=0, busy=0 immediately. A fresh arm + crossing then yields a complete frame starting with A5.
// - Arm handling: arm pulsed during CAPTURE and in the done cycle is ignored; arm one cycle after done starts a new ARMED.
// - Threshold latch: change threshold after arm. Expect trigger at the latched value; 14-bit max 0x3FFF triggers on trig_in=0x3FFF.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC trigger/capture block.
// State encoding, default widths and address-width helper.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    SEND
  } state_t;

  localparam int         SAMPLE_W_DEF = 14;
  localparam int         DEPTH_DEF    = 64;
  localparam logic [7:0] HEADER_DEF   = 8'hA5;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer, one write and one registered read.
// No reset so the array maps onto block RAM.
module capture_ram
  import adc_cap_pkg::*;
#(
  parameter int W     = SAMPLE_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Threshold-triggered capture of delayed ADC samples, drained as a
// header-prefixed byte stream over valid/ready.
module adc_trigger_capture
  import adc_cap_pkg::*;
#(
  parameter int         SAMPLE_W = SAMPLE_W_DEF,
  parameter int         DEPTH    = DEPTH_DEF,
  parameter logic [7:0] HEADER   = HEADER_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] trig_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic                arm,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done
);

  localparam int AW = addr_w(DEPTH);
  localparam int IW = AW + 2;
  localparam logic [AW-1:0] WLAST = AW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST  = IW'(2 * DEPTH + 1);

  state_t              state;
  logic [SAMPLE_W-1:0] thr_q;
  logic [SAMPLE_W-1:0] prev_q;
  logic [AW-1:0]       wr_cnt;
  logic [AW-1:0]       rd_addr;
  logic [IW-1:0]       idx;
  logic [7:0]          lo_q;
  logic [SAMPLE_W-1:0] rd_q;
  logic                crossing;
  logic                we;
  logic [AW-1:0]       waddr;
  logic                accept;

  assign crossing = (prev_q < thr_q) && (trig_in >= thr_q);
  assign we       = ((state == ARMED) && crossing) || (state == CAPTURE);
  assign waddr    = (state == CAPTURE) ? wr_cnt : '0;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

  capture_ram #(
    .W     (SAMPLE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (sample_in),
    .raddr (rd_addr),
    .rdata (rd_q)
  );

  // idx = next byte to load (0 header, odd hi, even lo); rd_q leads
  // by one sample, lo byte is parked in lo_q when the hi byte loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
      thr_q    <= '0;
      prev_q   <= '0;
      wr_cnt   <= '0;
      rd_addr  <= '0;
      idx      <= '0;
      lo_q     <= '0;
    end else begin
      prev_q <= trig_in;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arm) begin
            thr_q <= threshold;
            state <= ARMED;
          end
        end
        ARMED: begin
          if (crossing) begin
            wr_cnt <= AW'(1);
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (wr_cnt == WLAST) begin
            state    <= SEND;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
            idx      <= IW'(1);
          end else begin
            wr_cnt <= wr_cnt + 1'b1;
          end
        end
        SEND: begin
          if (done) begin
            state   <= IDLE;
            wr_cnt  <= '0;
            rd_addr <= '0;
            idx     <= '0;
          end else if (accept) begin
            if (idx == LAST) begin
              tx_valid <= 1'b0;
              done     <= 1'b1;
            end else if (idx[0]) begin
              tx_data <= 8'(rd_q >> 8);
              lo_q    <= rd_q[7:0];
              if (rd_addr != WLAST) rd_addr <= rd_addr + 1'b1;
              idx <= idx + 1'b1;
            end else begin
              tx_data <= lo_q;
              idx     <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Scoreboard bench for adc_trigger_capture: directed captures with
// a 20-tap delay model, backpressure, reset abort and arm handling.
module tb_adc_trigger_capture;

  localparam int SW = 14;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] trig_in = '0;
  logic [SW-1:0] sample_in;
  logic [SW-1:0] threshold = '0;
  logic          arm = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;

  logic [SW-1:0] dl [20];
  logic [7:0]    expq [$];
  int n_vec = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int c0 = 0;
  int cd = 0;
  int rmode = 0;
  int pcnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held = '0;

  adc_trigger_capture #(
    .SAMPLE_W (SW),
    .DEPTH    (DP),
    .HEADER   (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig_in   (trig_in),
    .sample_in (sample_in),
    .threshold (threshold),
    .arm       (arm),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 19; i > 0; i--) dl[i] <= dl[i-1];
    dl[0] <= trig_in;
    cyc <= cyc + 1;
  end
  assign sample_in = dl[19];

  always @(posedge clk) begin
    #1;
    if (rmode == 1) begin
      tx_ready = (pcnt % 3 == 0);
      pcnt++;
    end else if (rmode == 2) begin
      tx_ready = 1'($urandom_range(0, 1));
    end else if (rmode == 3) begin
      tx_ready = 1'b0;
    end else begin
      tx_ready = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_data", 32'(tx_data), 32'(held));
      end
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (expq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          chk("byte", 32'(tx_data), 32'(expq.pop_front()));
        end
      end
      stall_prev = tx_valid && !tx_ready;
      held = tx_data;
      if (done) done_cnt++;
    end
  end

  task automatic push_frame(input logic [SW-1:0] first);
    logic [SW-1:0] s;
    expq.push_back(8'hA5);
    for (int i = 0; i < DP; i++) begin
      s = first + SW'(i);
      expq.push_back({2'b00, s[13:8]});
      expq.push_back(s[7:0]);
    end
  endtask

  // Cycle 0 arms; crossing at cycle 25 captures trig of cycles 5..12.
  task automatic start_capture(input logic [SW-1:0] thr, input logic [SW-1:0] base,
                               input logic [SW-1:0] v24, input logic [SW-1:0] vx);
    push_frame(base + SW'(5));
    @(posedge clk); #1;
    threshold = thr;
    arm = 1'b1;
    trig_in = base;
    c0 = cyc;
    for (int k = 1; k <= 27; k++) begin
      @(posedge clk); #1;
      arm = (k == 27);
      if (k == 1) threshold = ~thr;
      trig_in = (k < 24) ? base + SW'(k) : (k == 24) ? v24 : vx;
    end
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic wait_done(input int arm_mode);
    bit seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
      return;
    end
    cd = cyc;
    if (arm_mode == 1) begin
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      chk("arm_in_done_ignored", 32'(busy), 32'd0);
    end else if (arm_mode == 2) begin
      @(posedge clk); #1;
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      chk("arm_after_done", 32'(busy), 32'd1);
    end else begin
      @(posedge clk); #1;
      chk("idle_after_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_frame(input logic [SW-1:0] thr, input logic [SW-1:0] base,
                           input logic [SW-1:0] v24, input logic [SW-1:0] vx,
                           input int arm_mode);
    start_capture(thr, base, v24, vx);
    wait_done(arm_mode);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    arm = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic hold_check(input string nm, input logic [SW-1:0] thr,
                            input logic [SW-1:0] la, input logic [SW-1:0] lb);
    @(posedge clk); #1;
    trig_in = la;
    @(posedge clk); #1;
    threshold = thr;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      trig_in = (n % 2 == 1) ? lb : la;
    end
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_valid"}, 32'(tx_valid), 32'd0);
    do_reset();
  endtask

  initial begin
    int a0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    rmode = 0;
    run_frame(14'h1000, 14'h0A37, 14'h0FF0, 14'h1000, 0);
    chk("frame_latency", 32'((cd - c0) <= 51), 32'd1);

    rmode = 1;
    run_frame(14'h2000, 14'h1A00, 14'h1FFF, 14'h2345, 0);
    rmode = 2;
    run_frame(14'h0800, 14'h0010, 14'h07FF, 14'h3000, 0);

    rmode = 0;
    run_frame(14'h1000, 14'h0B00, 14'h0FF0, 14'h1000, 1);
    run_frame(14'h1000, 14'h0C00, 14'h0FF0, 14'h1000, 2);
    do_reset();

    hold_check("below", 14'h1000, 14'h0FFF, 14'h0FFF);
    hold_check("above", 14'h1000, 14'h1800, 14'h1800);
    hold_check("thr0", 14'h0000, 14'h0000, 14'h3FFF);

    rmode = 1;
    a0 = acc_cnt;
    start_capture(14'h1000, 14'h0D00, 14'h0FF0, 14'h1000);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #2;
      if (acc_cnt - a0 >= 5) break;
    end
    if (acc_cnt - a0 < 5) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got %0d bytes expected 5", acc_cnt - a0);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(tx_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rmode = 0;
    run_frame(14'h1000, 14'h0E00, 14'h0FF0, 14'h1000, 0);

    run_frame(14'h3FFF, 14'h2222, 14'h3FFE, 14'h3FFF, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(expq.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
